fetch_prefetch_unit: RTL and testbench

//  Next-generation fetch stage: decouples instruction memory from decode with a parametrised

---
 rtl/fetch_prefetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: pipelined OBI instruction reads feeding a show-ahead prefetch FIFO.
// A redirect flushes the FIFO and drops the responses of reads already in flight.
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN            = 64,
    parameter logic [XLEN-1:0] RESET_ADDR      = '0,
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    output logic            imem_req_o,
    input  logic            imem_gnt_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_err_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] next_pc_o,
    output logic            fault_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    state_e            r_state;
    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_resp_pc;
    logic [XLEN-1:0]   r_pend_addr;
    logic              r_stale;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_discard;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [31:0]       r_fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0]   r_fifo_pc    [FIFO_DEPTH];
    logic              r_fifo_fault [FIFO_DEPTH];

    logic [CW:0]       w_credit_sum;
    logic              w_allowed;
    logic              w_in_pend;
    logic              w_req;
    logic              w_gnt;
    logic              w_gnt_stale;
    logic              w_gnt_live;
    logic              w_drop;
    logic              w_rsp;
    logic              w_empty;
    logic              w_pop;
    logic [XLEN-1:0]   w_redir_pc;
    logic [CW-1:0]     w_inflight;

    // Credits count only live requests, so every accepted response has a free slot.
    assign w_credit_sum = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_allowed    = (r_outstanding < CW'(MAX_OUTSTANDING)) &&
                          (w_credit_sum < (CW+1)'(FIFO_DEPTH));

    assign w_in_pend   = (r_state == StPend);
    assign w_req       = ~rst_i & (w_in_pend | (w_allowed & ~redirect_i));
    assign w_gnt       = w_req & imem_gnt_i;
    assign w_gnt_stale = w_gnt & w_in_pend & r_stale;
    assign w_gnt_live  = w_gnt & ~(w_in_pend & r_stale);
    assign w_drop      = imem_rvalid_i & (r_discard != '0);
    assign w_rsp       = imem_rvalid_i & (r_discard == '0);
    assign w_empty     = (r_count == '0);
    assign w_pop       = ~w_empty & ready_i;
    assign w_redir_pc  = {redirect_addr_i[XLEN-1:2], 2'b00};
    // Everything still on the bus after a redirect must be dropped on return.
    assign w_inflight  = r_discard + r_outstanding + CW'(w_gnt) - CW'(imem_rvalid_i);

    assign imem_req_o  = w_req;
    assign imem_addr_o = w_in_pend ? r_pend_addr : r_fetch_pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= StIdle;
            r_fetch_pc    <= RESET_ADDR;
            r_resp_pc     <= RESET_ADDR;
            r_pend_addr   <= '0;
            r_stale       <= 1'b0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else if (redirect_i) begin
            r_fetch_pc    <= w_redir_pc;
            r_resp_pc     <= w_redir_pc;
            r_outstanding <= '0;
            r_discard     <= w_inflight;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            if (w_in_pend) begin
                if (imem_gnt_i) begin
                    r_state <= StIdle;
                end else begin
                    r_stale <= 1'b1;
                end
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_req && !imem_gnt_i) begin
                        r_pend_addr <= r_fetch_pc;
                        r_stale     <= 1'b0;
                        r_state     <= StPend;
                    end
                end
                StPend: begin
                    if (imem_gnt_i) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
            if (w_gnt_live) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            r_outstanding <= r_outstanding + CW'(w_gnt_live) - CW'(w_rsp);
            r_discard     <= r_discard + CW'(w_gnt_stale) - CW'(w_drop);
            if (w_rsp) begin
                r_resp_pc <= r_resp_pc + XLEN'(4);
                r_wptr    <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_rsp) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_rsp && !redirect_i) begin
            r_fifo_instr[r_wptr] <= imem_err_i ? 32'h0 : imem_rdata_i;
            r_fifo_pc[r_wptr]    <= r_resp_pc;
            r_fifo_fault[r_wptr] <= imem_err_i;
        end
    end

    assign valid_o   = ~w_empty;
    assign instr_o   = w_empty ? 32'h0 : r_fifo_instr[r_rptr];
    assign pc_o      = w_empty ? '0 : r_fifo_pc[r_rptr];
    assign next_pc_o = w_empty ? '0 : r_fifo_pc[r_rptr] + XLEN'(4);
    assign fault_o   = w_empty ? 1'b0 : r_fifo_fault[r_rptr];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: zero-wait OBI memory model with optional
// grant stall, response hold and error injection.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [63:0] redirect_addr_i;
    logic        imem_req_o;
    logic        imem_gnt_i;
    logic [63:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        imem_err_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic [63:0] next_pc_o;
    logic        fault_o;

    int          checks = 0;
    int          errors = 0;

    logic        gnt_en;
    logic        hold;
    logic        err_en;
    logic [63:0] err_addr;
    logic [63:0] rsp_addr;
    logic [63:0] mq[$];
    logic [63:0] glog[$];

    fetch_prefetch_unit dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .imem_req_o      (imem_req_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_addr_o     (imem_addr_o),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .imem_err_i      (imem_err_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .next_pc_o       (next_pc_o),
        .fault_o         (fault_o)
    );

    always #5 clk = ~clk;

    assign imem_gnt_i = imem_req_o & gnt_en;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    // Accepted requests are logged mid-cycle; responses come one cycle later, in order.
    always @(negedge clk) begin
        if (rst_i) begin
            mq.delete();
        end else if (imem_req_o && imem_gnt_i) begin
            mq.push_back(imem_addr_o);
            glog.push_back(imem_addr_o);
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst_i && !hold && mq.size() > 0) begin
            rsp_addr      = mq.pop_front();
            imem_rvalid_i = 1'b1;
            imem_err_i    = err_en && (rsp_addr == err_addr);
            imem_rdata_i  = imem_err_i ? 32'hFFFF_FFFF : mem_word(rsp_addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_err_i    = 1'b0;
            imem_rdata_i  = 32'h0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max_cycles, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            step();
            sample();
            found = valid_o;
        end
    endtask

    task automatic do_reset();
        rst_i           = 1'b1;
        ready_i         = 1'b1;
        redirect_i      = 1'b0;
        redirect_addr_i = 64'h0;
        gnt_en          = 1'b1;
        hold            = 1'b0;
        err_en          = 1'b0;
        err_addr        = 64'h0;
        step();
        step();
        glog.delete();
    endtask

    task automatic test_reset();
        do_reset();
        sample();
        checks++;
        if ({imem_req_o, valid_o, fault_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got req/valid/fault=%b%b%b want 000",
                     imem_req_o, valid_o, fault_o);
        end
        checks++;
        if ({instr_o, pc_o, next_pc_o} !== 160'h0) begin
            errors++;
            $display("FAIL reset_data got instr=%h pc=%h npc=%h want all 0",
                     instr_o, pc_o, next_pc_o);
        end
    endtask

    task automatic test_stream();
        logic [63:0] exp_pc;
        step();
        rst_i = 1'b0;
        sample();
        checks++;
        if ({imem_req_o, imem_addr_o, valid_o} !== {1'b1, 64'h0, 1'b0}) begin
            errors++;
            $display("FAIL stream_c1 got req=%b addr=%h valid=%b want 1 0 0",
                     imem_req_o, imem_addr_o, valid_o);
        end
        step();
        sample();
        checks++;
        if ({imem_req_o, imem_addr_o, valid_o} !== {1'b1, 64'h4, 1'b0}) begin
            errors++;
            $display("FAIL stream_c2 got req=%b addr=%h valid=%b want 1 4 0",
                     imem_req_o, imem_addr_o, valid_o);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            sample();
            exp_pc = 64'(4 * k);
            checks++;
            if ({valid_o, pc_o, next_pc_o, instr_o, fault_o} !==
                {1'b1, exp_pc, exp_pc + 64'h4, mem_word(exp_pc), 1'b0}) begin
                errors++;
                $display("FAIL stream_out k=%0d got v=%b pc=%h npc=%h instr=%h f=%b want pc=%h",
                         k, valid_o, pc_o, next_pc_o, instr_o, fault_o, exp_pc);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_pc;
        do_reset();
        ready_i = 1'b0;
        step();
        rst_i = 1'b0;
        repeat (20) step();
        sample();
        checks++;
        if (glog.size() != 4 || glog[3] !== 64'hC) begin
            errors++;
            $display("FAIL bp_grants got %0d grants want 4 ending at 0xC", glog.size());
        end
        checks++;
        if ({imem_req_o, valid_o, pc_o} !== {1'b0, 1'b1, 64'h0}) begin
            errors++;
            $display("FAIL bp_hold got req=%b valid=%b pc=%h want 0 1 0",
                     imem_req_o, valid_o, pc_o);
        end
        step();
        ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sample();
            exp_pc = 64'(4 * k);
            checks++;
            if ({valid_o, pc_o, instr_o} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
                errors++;
                $display("FAIL bp_drain k=%0d got v=%b pc=%h instr=%h want pc=%h",
                         k, valid_o, pc_o, instr_o, exp_pc);
            end
            step();
        end
        checks++;
        if (glog.size() < 5 || glog[4] !== 64'h10) begin
            errors++;
            $display("FAIL bp_restart got %0d grants want fifth at 0x10", glog.size());
        end
    endtask

    task automatic test_redirect_outstanding();
        bit found;
        do_reset();
        hold = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        step();
        sample();
        checks++;
        if (imem_req_o !== 1'b0 || glog.size() != 2) begin
            errors++;
            $display("FAIL redir_credit got req=%b grants=%0d want 0 2", imem_req_o, glog.size());
        end
        step();
        redirect_i      = 1'b1;
        redirect_addr_i = 64'h1003;
        sample();
        checks++;
        if (imem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_cycle_req got %b want 0", imem_req_o);
        end
        step();
        redirect_i = 1'b0;
        hold       = 1'b0;
        sample();
        checks++;
        if ({imem_req_o, imem_addr_o, valid_o} !== {1'b1, 64'h1000, 1'b0}) begin
            errors++;
            $display("FAIL redir_next_addr got req=%b addr=%h valid=%b want 1 1000 0",
                     imem_req_o, imem_addr_o, valid_o);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            sample();
            checks++;
            if (valid_o !== 1'b0) begin
                errors++;
                $display("FAIL redir_drop i=%0d got valid=%b pc=%h want valid 0", i, valid_o, pc_o);
            end
        end
        wait_valid(8, found);
        checks++;
        if (!found || pc_o !== 64'h1000 || instr_o !== mem_word(64'h1000)) begin
            errors++;
            $display("FAIL redir_first got found=%b pc=%h instr=%h want pc=1000", found, pc_o,
                     instr_o);
        end
    endtask

    task automatic test_gnt_stall();
        bit found;
        do_reset();
        gnt_en = 1'b0;
        step();
        rst_i = 1'b0;
        sample();
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 64'h0}) begin
            errors++;
            $display("FAIL stall_c1 got req=%b addr=%h want 1 0", imem_req_o, imem_addr_o);
        end
        step();
        redirect_i      = 1'b1;
        redirect_addr_i = 64'h2000;
        sample();
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 64'h0}) begin
            errors++;
            $display("FAIL stall_redir got req=%b addr=%h want 1 0", imem_req_o, imem_addr_o);
        end
        step();
        redirect_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++;
            if ({imem_req_o, imem_addr_o} !== {1'b1, 64'h0}) begin
                errors++;
                $display("FAIL stall_hold i=%0d got req=%b addr=%h want 1 0", i, imem_req_o,
                         imem_addr_o);
            end
            step();
        end
        gnt_en = 1'b1;
        sample();
        step();
        sample();
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 64'h2000}) begin
            errors++;
            $display("FAIL stall_target got req=%b addr=%h want 1 2000", imem_req_o, imem_addr_o);
        end
        wait_valid(8, found);
        checks++;
        if (!found || pc_o !== 64'h2000 || instr_o !== mem_word(64'h2000)) begin
            errors++;
            $display("FAIL stall_first got found=%b pc=%h instr=%h want pc=2000", found, pc_o,
                     instr_o);
        end
    endtask

    task automatic test_fault();
        logic [63:0] exp_pc;
        do_reset();
        err_en   = 1'b1;
        err_addr = 64'h8;
        step();
        rst_i = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            sample();
            exp_pc = 64'(4 * k);
            checks++;
            if ({valid_o, pc_o, fault_o, instr_o} !==
                {1'b1, exp_pc, (k == 2), (k == 2) ? 32'h0 : mem_word(exp_pc)}) begin
                errors++;
                $display("FAIL fault k=%0d got v=%b pc=%h f=%b instr=%h want pc=%h f=%b",
                         k, valid_o, pc_o, fault_o, instr_o, exp_pc, (k == 2));
            end
        end
    endtask

    task automatic test_reset_midflight_wrap();
        bit found;
        do_reset();
        ready_i = 1'b0;
        step();
        rst_i = 1'b0;
        step();
        step();
        hold = 1'b1;
        step();
        step();
        sample();
        checks++;
        if ({valid_o, pc_o, imem_req_o} !== {1'b1, 64'h0, 1'b0} || glog.size() != 4) begin
            errors++;
            $display("FAIL mid_setup got v=%b pc=%h req=%b grants=%0d want 1 0 0 4",
                     valid_o, pc_o, imem_req_o, glog.size());
        end
        #1;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({imem_req_o, valid_o, fault_o, instr_o, pc_o, next_pc_o} !== 163'h0) begin
            errors++;
            $display("FAIL mid_async_rst got req=%b v=%b pc=%h instr=%h want all 0",
                     imem_req_o, valid_o, pc_o, instr_o);
        end
        step();
        step();
        hold    = 1'b0;
        ready_i = 1'b1;
        rst_i   = 1'b0;
        sample();
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 64'h0}) begin
            errors++;
            $display("FAIL mid_restart got req=%b addr=%h want 1 0", imem_req_o, imem_addr_o);
        end
        wait_valid(8, found);
        checks++;
        if (!found || pc_o !== 64'h0 || instr_o !== mem_word(64'h0)) begin
            errors++;
            $display("FAIL mid_first got found=%b pc=%h instr=%h want pc=0", found, pc_o, instr_o);
        end
        step();
        redirect_i      = 1'b1;
        redirect_addr_i = 64'hFFFF_FFFF_FFFF_FFFF;
        sample();
        step();
        redirect_i = 1'b0;
        sample();
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_top got req=%b addr=%h want 1 fffffffffffffffc", imem_req_o,
                     imem_addr_o);
        end
        step();
        sample();
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 64'h0}) begin
            errors++;
            $display("FAIL wrap_next got req=%b addr=%h want 1 0", imem_req_o, imem_addr_o);
        end
        wait_valid(8, found);
        checks++;
        if (!found || pc_o !== 64'hFFFF_FFFF_FFFF_FFFC || next_pc_o !== 64'h0) begin
            errors++;
            $display("FAIL wrap_out got found=%b pc=%h npc=%h want fffffffffffffffc 0",
                     found, pc_o, next_pc_o);
        end
        step();
        sample();
        checks++;
        if ({valid_o, pc_o, next_pc_o} !== {1'b1, 64'h0, 64'h4}) begin
            errors++;
            $display("FAIL wrap_after got v=%b pc=%h npc=%h want 1 0 4", valid_o, pc_o, next_pc_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_outstanding();
        test_gnt_stall();
        test_fault();
        test_reset_midflight_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
